// File: rtl/fpga_boot_pkg.sv
// Shared types and constants for the FPGA Caliptra boot sequencer.
// The optional readback check is enabled with FPGA_BOOT_VERIFY_EN.
package fpga_boot_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StVerify  = 3'd2,
        StPwrWait = 3'd3,
        StRun     = 3'd4,
        StRstHold = 3'd5,
        StError   = 3'd6
    } boot_state_e;

    // Shared by the PWRGOOD_DLY and RST_HOLD gaps, so sized for the larger of the two.
    localparam int unsigned DLY_CNT_W       = 16;
    localparam int unsigned IMEM_WORD_BYTES = 4;

    function automatic logic [DLY_CNT_W-1:0] dly_val(input int unsigned cycles);
        return DLY_CNT_W'(cycles);
    endfunction

endpackage

// File: rtl/fpga_boot_dly_cnt.sv
// Loadable down-counter; done pulses on the last counted cycle so the owner
// leaves its state exactly load_val cycles after the load.
module fpga_boot_dly_cnt
    import fpga_boot_pkg::*;
#(
    parameter int unsigned CNT_W = DLY_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && !load && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fpga_boot_seq_ctrl.sv
// Caliptra boot sequencer: streams a ROM image into imem port B, then releases
// pwrgood and reset in order. Define FPGA_BOOT_VERIFY_EN to add image readback.
module fpga_boot_seq_ctrl
    import fpga_boot_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 13,
    parameter int unsigned PWRGOOD_DLY = 16,
    parameter int unsigned RST_HOLD    = 8
) (
    input  logic                   core_clk,
    input  logic                   cptra_rst_b,
    input  logic                   load_start,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [31:0]            load_data,
    input  logic                   load_last,
    input  logic                   reboot_req,
    output logic                   imem_b_en,
    output logic [3:0]             imem_b_we,
    output logic [IMEM_ADDR_W-1:0] imem_b_addr,
    output logic [31:0]            imem_b_wrdata,
    input  logic [31:0]            imem_b_rddata,
    output logic                   cptra_pwrgood_o,
    output logic                   cptra_rst_b_o,
    output logic [IMEM_ADDR_W:0]   word_count,
    output logic [31:0]            checksum,
    output logic [2:0]             state,
    output logic                   error
);

    localparam int unsigned WC_W = IMEM_ADDR_W + 1;

`ifdef FPGA_BOOT_VERIFY_EN
    localparam boot_state_e POST_LOAD = StVerify;
`else
    localparam boot_state_e POST_LOAD = StPwrWait;
`endif

    boot_state_e     state_q, state_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [31:0]     sum_q, sum_d;
    logic            err_q, err_d;
    logic            pwr_q, pwr_d;
    logic            rstb_q, rstb_d;

    logic                 full;
    logic                 beat;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_done;
    logic [DLY_CNT_W-1:0] cnt_val;

`ifdef FPGA_BOOT_VERIFY_EN
    logic [WC_W-1:0] rd_addr_q, rd_addr_d;
    logic            rd_vld_q, rd_vld_d;
    logic [31:0]     rd_sum_q, rd_sum_d;
`else
    logic unused_rddata;
    assign unused_rddata = ^imem_b_rddata;
`endif

    // The top count bit is set only when imem is completely filled.
    assign full   = wc_q[IMEM_ADDR_W];
    assign cnt_en = (state_q == StPwrWait) || (state_q == StRstHold);

    always_comb begin
        state_d       = state_q;
        wc_d          = wc_q;
        sum_d         = sum_q;
        err_d         = err_q;
        pwr_d         = pwr_q;
        rstb_d        = rstb_q;
        load_ready    = 1'b0;
        beat          = 1'b0;
        imem_b_en     = 1'b0;
        imem_b_we     = '0;
        imem_b_addr   = '0;
        imem_b_wrdata = '0;
        cnt_load      = 1'b0;
        cnt_val       = '0;
`ifdef FPGA_BOOT_VERIFY_EN
        rd_addr_d = '0;
        rd_vld_d  = 1'b0;
        rd_sum_d  = '0;
`endif

        unique case (state_q)
            StIdle, StError: begin
                if (load_start) begin
                    state_d = StLoad;
                    wc_d    = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                load_ready = !full;
                beat       = load_valid && !full;
                if (beat) begin
                    imem_b_en     = 1'b1;
                    imem_b_we     = {IMEM_WORD_BYTES{1'b1}};
                    imem_b_addr   = wc_q[IMEM_ADDR_W-1:0];
                    imem_b_wrdata = load_data;
                    wc_d          = wc_q + WC_W'(1);
                    sum_d         = sum_q + load_data;
                end
                if (load_valid && full) begin
                    err_d   = 1'b1;
                    state_d = StError;
                end else if (load_last) begin
                    if ((wc_q == '0) && !beat) begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end else begin
                        state_d = POST_LOAD;
                    end
                end
            end
`ifdef FPGA_BOOT_VERIFY_EN
            StVerify: begin
                rd_addr_d = rd_addr_q;
                rd_sum_d  = rd_sum_q;
                if (rd_addr_q != wc_q) begin
                    imem_b_en   = 1'b1;
                    imem_b_addr = rd_addr_q[IMEM_ADDR_W-1:0];
                    rd_addr_d   = rd_addr_q + WC_W'(1);
                    rd_vld_d    = 1'b1;
                end
                if (rd_vld_q) begin
                    rd_sum_d = rd_sum_q + imem_b_rddata;
                end else if (rd_addr_q == wc_q) begin
                    if (rd_sum_q == sum_q) begin
                        state_d = StPwrWait;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
            end
`endif
            StPwrWait: begin
                if (cnt_done) begin
                    rstb_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
            end
            StRstHold: begin
                if (cnt_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_d == StPwrWait) && (state_q != StPwrWait)) begin
            pwr_d    = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = dly_val(PWRGOOD_DLY);
        end

        // Reboot overrides every other transition, including a pending load_last.
        if (reboot_req && (state_q != StIdle) && (state_q != StError)) begin
            state_d  = StRstHold;
            pwr_d    = 1'b0;
            rstb_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = dly_val(RST_HOLD);
`ifdef FPGA_BOOT_VERIFY_EN
            rd_addr_d = '0;
            rd_vld_d  = 1'b0;
            rd_sum_d  = '0;
`endif
        end
    end

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_q <= StIdle;
            wc_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            pwr_q   <= 1'b0;
            rstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            pwr_q   <= pwr_d;
            rstb_q  <= rstb_d;
        end
    end

`ifdef FPGA_BOOT_VERIFY_EN
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_sum_q  <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= rd_vld_d;
            rd_sum_q  <= rd_sum_d;
        end
    end
`endif

    fpga_boot_dly_cnt #(
        .CNT_W(DLY_CNT_W)
    ) u_dly_cnt (
        .clk     (core_clk),
        .rst_n   (cptra_rst_b),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (cnt_en),
        .done    (cnt_done)
    );

    assign cptra_pwrgood_o = pwr_q;
    assign cptra_rst_b_o   = rstb_q;
    assign word_count      = wc_q;
    assign checksum        = sum_q;
    assign state           = state_q;
    assign error           = err_q;

endmodule

// File: tb/tb_fpga_boot_seq_ctrl.sv
// Directed bench for fpga_boot_seq_ctrl with a 4-word imem model on port B.
// Readback cases are included when FPGA_BOOT_VERIFY_EN is defined.
module tb_fpga_boot_seq_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned PD = 16;
    localparam int unsigned RH = 8;

    logic          core_clk = 1'b0;
    logic          cptra_rst_b = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          reboot_req = 1'b0;
    logic          imem_b_en;
    logic [3:0]    imem_b_we;
    logic [AW-1:0] imem_b_addr;
    logic [31:0]   imem_b_wrdata;
    logic [31:0]   imem_b_rddata = '0;
    logic          cptra_pwrgood_o;
    logic          cptra_rst_b_o;
    logic [AW:0]   word_count;
    logic [31:0]   checksum;
    logic [2:0]    state;
    logic          error;

    logic [31:0] mem [4];
    logic        corrupt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 core_clk = ~core_clk;

    fpga_boot_seq_ctrl #(
        .IMEM_ADDR_W(AW),
        .PWRGOOD_DLY(PD),
        .RST_HOLD   (RH)
    ) dut (
        .core_clk       (core_clk),
        .cptra_rst_b    (cptra_rst_b),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_last      (load_last),
        .reboot_req     (reboot_req),
        .imem_b_en      (imem_b_en),
        .imem_b_we      (imem_b_we),
        .imem_b_addr    (imem_b_addr),
        .imem_b_wrdata  (imem_b_wrdata),
        .imem_b_rddata  (imem_b_rddata),
        .cptra_pwrgood_o(cptra_pwrgood_o),
        .cptra_rst_b_o  (cptra_rst_b_o),
        .word_count     (word_count),
        .checksum       (checksum),
        .state          (state),
        .error          (error)
    );

    // Port B BRAM with 1-cycle read latency; corrupt flips bit 0 of word 1.
    always @(posedge core_clk) begin
        if (imem_b_en) begin
            if (imem_b_we == 4'hF) mem[imem_b_addr] <= imem_b_wrdata;
            imem_b_rddata <= mem[imem_b_addr];
        end
        if (corrupt) mem[1] <= mem[1] ^ 32'h1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, output int k);
        k = 0;
        while (state !== s && k < limit) begin
            step();
            k++;
        end
    endtask

    initial begin
        int k;
        logic pg_seen;

        #3;
        chk("rst_state", state, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_en", imem_b_en, 0);
        chk("rst_we", imem_b_we, 0);
        chk("rst_addr", imem_b_addr, 0);
        chk("rst_wrdata", imem_b_wrdata, 0);
        chk("rst_pwrgood", cptra_pwrgood_o, 0);
        chk("rst_rstb", cptra_rst_b_o, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_sum", checksum, 0);
        chk("rst_err", error, 0);
        #4;
        cptra_rst_b = 1'b1;
        step();

        // IDLE ignores load_valid
        load_valid = 1'b1;
        load_data  = 32'h55;
        #1;
        chk("idle_ready", load_ready, 0);
        chk("idle_en", imem_b_en, 0);
        step();
        load_valid = 1'b0;
        chk("idle_state", state, 0);
        chk("idle_wc", word_count, 0);

        // Normal boot: words 1..4 back-to-back
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_state", state, 1);
        for (int i = 1; i <= 4; i++) begin
            load_valid = 1'b1;
            load_data  = i;
            #1;
            chk("wr_ready", load_ready, 1);
            chk("wr_en", imem_b_en, 1);
            chk("wr_we", imem_b_we, 4'hF);
            chk("wr_addr", imem_b_addr, i - 1);
            chk("wr_data", imem_b_wrdata, i);
            step();
        end
        load_valid = 1'b0;
        #1;
        chk("boot_wc", word_count, 4);
        chk("boot_sum", checksum, 10);
        chk("boot_full_ready", load_ready, 0);
        chk("mem0", mem[0], 1);
        chk("mem3", mem[3], 4);
        load_last = 1'b1;
        step();
        load_last = 1'b0;
`ifdef FPGA_BOOT_VERIFY_EN
        chk("verify_state", state, 2);
        chk("verify_pg_low", cptra_pwrgood_o, 0);
        k = 0;
        while (!cptra_pwrgood_o && k < 50) begin
            step();
            k++;
        end
        chk("verify_latency", k, 6);
`endif
        chk("pw_state", state, 3);
        chk("pw_pwrgood", cptra_pwrgood_o, 1);
        chk("pw_rstb", cptra_rst_b_o, 0);
        k = 0;
        while (!cptra_rst_b_o && k < 100) begin
            step();
            k++;
        end
        chk("pwrgood_gap", k, PD);
        chk("run_state", state, 4);
        chk("run_pwrgood", cptra_pwrgood_o, 1);

        // RUN ignores load_start
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("run_ign_start", state, 4);

        // Reboot from RUN
        reboot_req = 1'b1;
        step();
        reboot_req = 1'b0;
        chk("rb_pwrgood", cptra_pwrgood_o, 0);
        chk("rb_rstb", cptra_rst_b_o, 0);
        chk("rb_state", state, 5);
        wait_state(3'd0, 50, k);
        chk("rst_hold_len", k, RH);
        chk("rb_wc_kept", word_count, 4);
        chk("rb_sum_kept", checksum, 10);

        // Boundary: load_last with the 4th beat
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        beat(32'd5);
        beat(32'd6);
        beat(32'd7);
        load_last = 1'b1;
        beat(32'd8);
        load_last = 1'b0;
        chk("bnd_wc", word_count, 4);
        chk("bnd_sum", checksum, 26);
        chk("bnd_mem3", mem[3], 8);
`ifdef FPGA_BOOT_VERIFY_EN
        chk("bnd_state", state, 2);
`else
        chk("bnd_state", state, 3);
`endif
        wait_state(3'd4, 100, k);
        chk("bnd_run", state, 4);
        chk("bnd_rstb", cptra_rst_b_o, 1);
        reboot_req = 1'b1;
        step();
        reboot_req = 1'b0;
        wait_state(3'd0, 50, k);
        chk("bnd_idle", state, 0);

        // Checksum wrap, then reboot beats load_last in the same cycle
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        beat(32'hFFFF_FFFF);
        beat(32'h2);
        chk("wrap_sum", checksum, 32'h1);
        chk("wrap_wc", word_count, 2);
        load_last  = 1'b1;
        reboot_req = 1'b1;
        step();
        load_last  = 1'b0;
        reboot_req = 1'b0;
        chk("rb_prio_state", state, 5);
        chk("rb_prio_pg", cptra_pwrgood_o, 0);
        wait_state(3'd0, 50, k);
        chk("wrap_idle", state, 0);

        // Overflow: 5th word into a 4-word imem
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 1; i <= 4; i++) beat(i);
        load_valid = 1'b1;
        load_data  = 32'd5;
        #1;
        chk("ovf_ready", load_ready, 0);
        chk("ovf_en", imem_b_en, 0);
        step();
        load_valid = 1'b0;
        chk("ovf_state", state, 6);
        chk("ovf_err", error, 1);
        chk("ovf_wc", word_count, 4);
        repeat (20) step();
        chk("ovf_pg", cptra_pwrgood_o, 0);
        chk("ovf_rstb", cptra_rst_b_o, 0);
        reboot_req = 1'b1;
        step();
        reboot_req = 1'b0;
        chk("err_ign_reboot", state, 6);

        // Leave ERROR via load_start, then empty load_last
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("err_exit_state", state, 1);
        chk("err_exit_err", error, 0);
        chk("err_exit_wc", word_count, 0);
        load_last = 1'b1;
        step();
        load_last = 1'b0;
        chk("empty_state", state, 6);
        chk("empty_err", error, 1);

`ifdef FPGA_BOOT_VERIFY_EN
        // Corrupted readback
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 1; i <= 4; i++) beat(i);
        corrupt = 1'b1;
        step();
        corrupt = 1'b0;
        chk("corrupt_mem1", mem[1], 3);
        load_last = 1'b1;
        step();
        load_last = 1'b0;
        chk("vfail_state0", state, 2);
        pg_seen = 1'b0;
        repeat (6) begin
            step();
            if (cptra_pwrgood_o) pg_seen = 1'b1;
        end
        chk("vfail_state", state, 6);
        chk("vfail_err", error, 1);
        chk("vfail_pg_seen", pg_seen, 0);
`else
        pg_seen = 1'b0;
        chk("vfail_skip_pg", cptra_pwrgood_o, pg_seen);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_boot_seq_ctrl.md
Name: fpga_boot_seq_ctrl

Overview:
- Core-clock controller that owns imem BRAM port B in the FPGA wrapper and sequences Caliptra boot.
- Accepts a ROM image as a stream of 32-bit words and writes them into imem, keeping a running checksum.
- Optionally reads the image back and verifies it.
- Then releases cptra_pwrgood and cptra_rst_b to the Caliptra core in order, with programmable gaps between them.

Parameters:
- IMEM_ADDR_W, 13, word address width of port B; capacity is 2**IMEM_ADDR_W words.
- PWRGOOD_DLY, 16, cycles from cptra_pwrgood_o rising to cptra_rst_b_o rising; minimum 1.
- RST_HOLD, 8, cycles both boot outputs stay low after a reboot before returning to IDLE; minimum 1.

Ports:
- core_clk  in  1  block clock.
- cptra_rst_b  in  1  asynchronous active-low block reset.
- load_start  in  1  pulse; begin a new image load at address 0.
- load_valid  in  1  word-stream valid.
- load_ready  out  1  word-stream ready.
- load_data  in  32  image word.
- load_last  in  1  pulse; image complete, proceed to boot.
- reboot_req  in  1  pulse; drop Caliptra power and reset, return to IDLE.
- imem_b_en  out  1  port B enable.
- imem_b_we  out  4  port B byte write enables.
- imem_b_addr  out  IMEM_ADDR_W  port B word address.
- imem_b_wrdata  out  32  port B write data.
- imem_b_rddata  in  32  port B read data, 1-cycle latency.
- cptra_pwrgood_o  out  1  to Caliptra pwrgood.
- cptra_rst_b_o  out  1  to Caliptra reset.
- word_count  out  IMEM_ADDR_W+1  words accepted in the current load.
- checksum  out  32  wrapping sum of accepted words.
- state  out  3  current FSM state encoding.
- error  out  1  sticky error flag.

Behaviour:
- Reset, asynchronous and active-low on cptra_rst_b: state=IDLE.
  - load_ready, imem_b_en, imem_b_we, cptra_pwrgood_o, cptra_rst_b_o, error all 0.
  - word_count, checksum, imem_b_addr, imem_b_wrdata all 0.
- States: IDLE=0, LOAD=1, VERIFY=2, PWR_WAIT=3, RUN=4, RST_HOLD=5, ERROR=6.
- IDLE:
  - load_start clears word_count, checksum and error, then goes to LOAD.
  - load_valid is ignored.
- LOAD:
  - load_ready=1 while word_count < 2**IMEM_ADDR_W.
  - Accepted beat (valid & ready): same cycle drives imem_b_en=1, imem_b_we=4'hF, imem_b_addr=word_count, imem_b_wrdata=load_data.
  - Next cycle: word_count+1 and checksum+=load_data, mod 2^32.
  - One word per cycle maximum; back-to-back beats are allowed.
- Full image: if word_count == 2**IMEM_ADDR_W, load_ready=0; a load_valid then sets error and goes to ERROR.
- load_last while in LOAD:
  - Beat and load_last in the same cycle: the beat is accepted first, then the transition happens.
  - Exits to VERIFY if FPGA_BOOT_VERIFY_EN is defined, else to PWR_WAIT.
  - load_last with word_count==0 and no beat: sets error, goes to ERROR.
- PWR_WAIT:
  - cptra_pwrgood_o=1 on entry; a counter runs PWRGOOD_DLY cycles.
  - Then cptra_rst_b_o=1 and the FSM goes to RUN.
- RUN: outputs hold; load_start is ignored.
- reboot_req in any state except IDLE and ERROR:
  - Same-cycle exit; cptra_rst_b_o=0 next cycle, cptra_pwrgood_o=0 next cycle.
  - RST_HOLD counts RST_HOLD cycles, then goes to IDLE.
  - word_count and checksum are retained for readout.
- reboot_req has priority over load_last and load_start in the same cycle.
- ERROR: boot outputs held 0; leaves only via load_start, which restarts LOAD and clears error.
- Port B is never driven while cptra_rst_b_o=1, so Caliptra never sees a ROM change while running.

Optional Feature:
- Macro: FPGA_BOOT_VERIFY_EN.
- Defined: VERIFY state is compiled in.
  - Issues reads at addr 0..word_count-1: imem_b_en=1, imem_b_we=0, one read per cycle, pipelined.
  - Sums imem_b_rddata one cycle after each read.
  - After the last data returns, compares the read-back sum with checksum.
  - Match: go to PWR_WAIT (latency word_count+2 cycles). Mismatch: set error, go to ERROR.
  - reboot_req aborts verification.
- Undefined: no VERIFY logic; LOAD goes straight to PWR_WAIT; state encoding 2 is unused.

Decomposition:
- fpga_boot_pkg holds:
  - the boot_state_e enum (3-bit);
  - the widths of the PWRGOOD_DLY/RST_HOLD counters;
  - localparam IMEM_WORD_BYTES=4.
- One sub-module: fpga_boot_dly_cnt, a loadable down-counter with a done pulse, instantiated once and shared by PWR_WAIT and RST_HOLD.

Test Plan:
- Normal boot:
  - load_start, then 4 back-to-back words 1,2,3,4, then load_last.
  - Expect port B writes to addr 0..3, checksum=10, word_count=4.
  - cptra_pwrgood_o rises, cptra_rst_b_o rises exactly PWRGOOD_DLY cycles later, state=RUN.
- Boundary beat:
  - load_last in the same cycle as the 4th beat: that word is written and counted before PWR_WAIT.
- Overflow:
  - IMEM_ADDR_W=2, stream 5 words.
  - Expect load_ready=0 after 4 words, error=1 on the 5th valid, state=ERROR, boot outputs stay 0.
- Reboot mid-run:
  - reboot_req in RUN: both boot outputs 0 next cycle, state=RST_HOLD for RST_HOLD cycles, then IDLE.
  - A subsequent load boots again.
- Checksum wrap: words 32'hFFFF_FFFF and 32'h2 give checksum=32'h1.
- Verify path, FPGA_BOOT_VERIFY_EN defined:
  - Corrupt addr 1 via the bench BRAM model before readback: error=1, ERROR, pwrgood never asserted.
  - Without corruption: boot proceeds.
